scn_bus_initiator: RTL and testbench

// - 68000-style bus master that drives the TC0100SCN CPU port (VA/Din/UDSn/LDSn/SCCSn/RW, completes on DACKn).
// - Converts single-cycle host requests (debug loader, state restore, bench) into strobe cycles.
// - Sits between the host request logic and the tilemap chip's CPU port. Runs in the chip's ce_13m domain.

---
 rtl/scn_bus_initiator_if.sv | 44 ++++
 rtl/scn_bus_initiator.sv | 270 +++++++++++++++++++++++++++
 tb/tb_scn_bus_initiator.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scn_bus_initiator_if.sv
// -----------------------------------------------------------------------------
// scn_bus_initiator_if
//
// Purpose:
//   CPU-port bus between the scn_bus_initiator (68000-style master) and the
//   TC0100SCN tilemap chip. Grouping the wires here lets the initiator, the
//   chip, and a bench model all share one definition of the port.
//
// Signals:
//   VA     [16:0]  word address [17:1]; bit 16 (A17) selects control regs
//   DOUT   [15:0]  write data from the initiator to the chip Din
//   DIN    [15:0]  read data from the chip Dout
//   UDSn           upper data strobe, active low
//   LDSn           lower data strobe, active low
//   SCCSn          chip select, active low
//   RW             1 = read, 0 = write
//   DACKn          chip acknowledge, active low. The chip forces it low
//                  whenever SCCSn is high, so it only carries meaning while
//                  SCCSn is low.
//
// Modports:
//   master  the bus initiator
//   slave   the chip, or a model of it
// -----------------------------------------------------------------------------
interface scn_bus_initiator_if;
  logic [16:0] VA;
  logic [15:0] DOUT;
  logic [15:0] DIN;
  logic        UDSn;
  logic        LDSn;
  logic        SCCSn;
  logic        RW;
  logic        DACKn;

  modport master (
    output VA, DOUT, UDSn, LDSn, SCCSn, RW,
    input  DIN, DACKn
  );

  modport slave (
    input  VA, DOUT, UDSn, LDSn, SCCSn, RW,
    output DIN, DACKn
  );
endinterface

// File: rtl/scn_bus_initiator.sv
// -----------------------------------------------------------------------------
// scn_bus_initiator
//
// Purpose:
//   68000-style bus master for the TC0100SCN CPU port. It turns a one-clk
//   host request (debug loader, state restore, bench) into a full strobe
//   cycle: address/data setup, chip select plus data strobes, wait for
//   DACKn, then release with a recovery gap. It runs in the chip's ce_13m
//   domain: every change on the chip side and every DACKn sample happens on
//   a ce_13m tick. Host-side handshakes (request acceptance, ack) are on clk.
//
// Parameters:
//   RECOVERY_TICKS  ce ticks with SCCSn high after a cycle before the next
//                   one may start. The chip's CS edge detector needs >=1 to
//                   rearm. Must be >= 1.
//   TIMEOUT_TICKS   ce ticks spent in WAIT before the cycle is aborted.
//                   Only takes effect when SCN_BUS_TIMEOUT_EN is defined.
//
// Build option:
//   SCN_BUS_TIMEOUT_EN  when defined, a cycle that never sees DACKn is
//                       aborted after TIMEOUT_TICKS ce ticks in WAIT and
//                       completes with err=1, rdata=16'hFFFF. When not
//                       defined, WAIT waits indefinitely and err stays 0.
//
// Ports:
//   clk      in   system clock
//   resetn   in   synchronous reset, active low
//   ce_13m   in   13 MHz clock enable
//   req      in   one-clk request pulse; ignored while busy=1
//   addr     in   [16:0] word address [17:1]; bit 16 = control regs
//   we       in   1 = write, 0 = read
//   be       in   [1:0] byte enables {upper, lower}
//   wdata    in   [15:0] write data
//   rdata    out  [15:0] read data, valid on ack and held until next ack
//   ack      out  one-clk completion pulse
//   busy     out  high from request acceptance until return to IDLE
//   err      out  valid with ack; 1 = cycle aborted
//   bus      if   chip CPU port (scn_bus_initiator_if.master)
// -----------------------------------------------------------------------------
module scn_bus_initiator #(
  parameter int RECOVERY_TICKS = 2,
  parameter int TIMEOUT_TICKS  = 64
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ce_13m,
  input  logic                       req,
  input  logic [16:0]                addr,
  input  logic                       we,
  input  logic [1:0]                 be,
  input  logic [15:0]                wdata,
  output logic [15:0]                rdata,
  output logic                       ack,
  output logic                       busy,
  output logic                       err,
  scn_bus_initiator_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    WAIT,
    RELEASE
  } state_t;

  localparam int REC_W = (RECOVERY_TICKS < 2) ? 1 : $clog2(RECOVERY_TICKS + 1);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVERY_TICKS - 1);

  localparam int TO_W = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

`ifdef SCN_BUS_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  // Control state and latched request
  state_t            state_q, state_d;
  logic [16:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        be_q, be_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [REC_W-1:0]  rec_q, rec_d;
  logic [TO_W-1:0]   to_q, to_d;

  // Registered chip-side outputs
  logic [16:0]       va_q, va_d;
  logic [15:0]       dout_q, dout_d;
  logic              uds_n_q, uds_n_d;
  logic              lds_n_q, lds_n_d;
  logic              cs_n_q, cs_n_d;
  logic              rw_q, rw_d;

  // Registered host-side outputs
  logic [15:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  // Next-state and next-output logic. Every register holds by default;
  // ack and err are single-clk pulses and therefore default to 0.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rec_d   = rec_q;
    to_d    = to_q;
    va_d    = va_q;
    dout_d  = dout_q;
    uds_n_d = uds_n_q;
    lds_n_d = lds_n_q;
    cs_n_d  = cs_n_q;
    rw_d    = rw_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // busy is also raised for the one-clk no-op (be=00) completion,
        // so it must be dropped again here.
        busy_d = 1'b0;
        // Acceptance is gated on the registered busy so a request arriving
        // on the clk where busy falls is ignored.
        if (req && !busy_q) begin
          addr_d  = addr;
          we_d    = we;
          be_d    = be;
          wdata_d = wdata;
          busy_d  = 1'b1;
          if (be == 2'b00) begin
            // Nothing to strobe: complete immediately without touching the bus.
            ack_d = 1'b1;
          end else begin
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        // Address, data and direction settle one ce tick before select.
        if (ce_13m) begin
          va_d    = addr_q;
          dout_d  = wdata_q;
          rw_d    = ~we_q;
          state_d = STROBE;
        end
      end

      STROBE: begin
        // DACKn is not sampled on this tick: SCCSn is only now going low and
        // the chip holds DACKn low while SCCSn is high.
        if (ce_13m) begin
          cs_n_d  = 1'b0;
          uds_n_d = ~be_q[1];
          lds_n_d = ~be_q[0];
          to_d    = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (ce_13m) begin
          if (!bus.DACKn) begin
            if (!we_q) begin
              rdata_d = bus.DIN;
            end
            ack_d   = 1'b1;
            cs_n_d  = 1'b1;
            uds_n_d = 1'b1;
            lds_n_d = 1'b1;
            rw_d    = 1'b1;
            rec_d   = '0;
            state_d = RELEASE;
          end else if (TIMEOUT_ON && (to_q == TO_LAST)) begin
            // Abort: the chip never answered. Release the bus and report.
            rdata_d = 16'hFFFF;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            cs_n_d  = 1'b1;
            uds_n_d = 1'b1;
            lds_n_d = 1'b1;
            rw_d    = 1'b1;
            rec_d   = '0;
            state_d = RELEASE;
          end else if (to_q != '1) begin
            to_d = to_q + 1'b1;
          end
        end
      end

      RELEASE: begin
        // Strobes are already high; keep them so for the recovery gap.
        // The counter saturates instead of wrapping.
        if (ce_13m) begin
          if (rec_q >= REC_LAST) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (rec_q != '1) begin
            rec_d = rec_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset drops every strobe high on the next clk and
  // suppresses any pending ack/err.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 2'b00;
      wdata_q <= '0;
      rec_q   <= '0;
      to_q    <= '0;
      va_q    <= '0;
      dout_q  <= '0;
      uds_n_q <= 1'b1;
      lds_n_q <= 1'b1;
      cs_n_q  <= 1'b1;
      rw_q    <= 1'b1;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rec_q   <= rec_d;
      to_q    <= to_d;
      va_q    <= va_d;
      dout_q  <= dout_d;
      uds_n_q <= uds_n_d;
      lds_n_q <= lds_n_d;
      cs_n_q  <= cs_n_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.VA    = va_q;
  assign bus.DOUT  = dout_q;
  assign bus.UDSn  = uds_n_q;
  assign bus.LDSn  = lds_n_q;
  assign bus.SCCSn = cs_n_q;
  assign bus.RW    = rw_q;

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_scn_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_scn_bus_initiator
//
// Purpose:
//   Self-checking bench for scn_bus_initiator. Contains a small TC0100SCN
//   CPU-port model (8 control regs, 1K words of RAM) that answers control
//   accesses on the first WAIT tick and RAM accesses after a programmable
//   latency, and can hold DACKn high to force a timeout. Expected read data
//   and error flags are queued when a request is issued and popped on ack.
// -----------------------------------------------------------------------------
module tb_scn_bus_initiator;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ce_13m = 1'b0;
  logic        req = 1'b0;
  logic [16:0] addr = '0;
  logic        we = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  scn_bus_initiator_if bus ();

  scn_bus_initiator #(
    .RECOVERY_TICKS (2),
    .TIMEOUT_TICKS  (64)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .ce_13m (ce_13m),
    .req    (req),
    .addr   (addr),
    .we     (we),
    .be     (be),
    .wdata  (wdata),
    .rdata  (rdata),
    .ack    (ack),
    .busy   (busy),
    .err    (err),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ce_13m: one clk in four, changed on the falling edge
  int ce_div = 0;
  always @(negedge clk) begin
    ce_div = (ce_div + 1) % 4;
    ce_13m = (ce_div == 0);
  end

  int tick_cnt = 0;
  always @(posedge clk) if (ce_13m) tick_cnt <= tick_cnt + 1;

  // Chip model
  logic [15:0] ram [0:1023];
  logic [15:0] ctrl [0:7];
  logic        dack_reg = 1'b1;
  logic [15:0] din_reg = '0;
  int          lat_cnt = 0;
  int          ram_lat = 0;
  bit          hold_high = 1'b0;
  bit          done_acc = 1'b0;
  bit          pl_en = 1'b0;
  bit          pl_ctrl = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  assign bus.DIN   = din_reg;
  assign bus.DACKn = bus.SCCSn ? 1'b0 : dack_reg;

  always @(posedge clk) begin
    if (pl_en) begin
      if (pl_ctrl) ctrl[pl_addr[2:0]] <= pl_data;
      else         ram[pl_addr]       <= pl_data;
    end
    if (bus.SCCSn) begin
      dack_reg <= 1'b1;
      lat_cnt  <= 0;
      done_acc <= 1'b0;
    end else if (ce_13m && !hold_high && !done_acc) begin
      if (lat_cnt >= (bus.VA[16] ? 0 : ram_lat)) begin
        dack_reg <= 1'b0;
        done_acc <= 1'b1;
        if (bus.RW) begin
          din_reg <= bus.VA[16] ? ctrl[bus.VA[2:0]] : ram[bus.VA[9:0]];
        end else if (bus.VA[16]) begin
          if (!bus.UDSn) ctrl[bus.VA[2:0]][15:8] <= bus.DOUT[15:8];
          if (!bus.LDSn) ctrl[bus.VA[2:0]][7:0]  <= bus.DOUT[7:0];
        end else begin
          if (!bus.UDSn) ram[bus.VA[9:0]][15:8] <= bus.DOUT[15:8];
          if (!bus.LDSn) ram[bus.VA[9:0]][7:0]  <= bus.DOUT[7:0];
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;
  exp_t        exp_q [$];
  logic [15:0] last_rd = '0;
  int          total = 0;
  int          bad = 0;

  task automatic preload(input bit is_ctrl, input logic [9:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_ctrl = is_ctrl; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic issue(input logic [16:0] a, input logic w, input logic [1:0] b, input logic [15:0] d);
    @(negedge clk);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_ack(input int max_clks, output bit seen, output int ticks,
                          output int low_tick, output logic cu, output logic cl,
                          output logic crw, output logic [16:0] cva, output bit rw_low);
    int t0;
    t0 = tick_cnt;
    seen = 1'b0; low_tick = -1; rw_low = 1'b0;
    cu = 1'bx; cl = 1'bx; crw = 1'bx; cva = 'x;
    for (int i = 0; i < max_clks; i++) begin
      if (bus.RW === 1'b0) rw_low = 1'b1;
      if (bus.SCCSn === 1'b0 && low_tick < 0) begin
        low_tick = tick_cnt; cu = bus.UDSn; cl = bus.LDSn; crw = bus.RW; cva = bus.VA;
      end
      if (ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    ticks = tick_cnt - t0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if ({bus.SCCSn, bus.UDSn, bus.LDSn, bus.RW} !== 4'b1111) begin
      bad++; $display("[TB] FAIL reset_strobes: got %b want 1111", {bus.SCCSn, bus.UDSn, bus.LDSn, bus.RW});
    end
    total++;
    if ({bus.VA, bus.DOUT, rdata} !== 49'd0) begin
      bad++; $display("[TB] FAIL reset_data: got VA=%h DOUT=%h rdata=%h want 0", bus.VA, bus.DOUT, rdata);
    end
    total++;
    if ({ack, busy, err} !== 3'b000) begin
      bad++; $display("[TB] FAIL reset_flags: got %b want 000", {ack, busy, err});
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ctrl_write();
    bit seen, rw_low, ok; int ticks, low_tick; logic cu, cl, crw; logic [16:0] cva; exp_t e;
    preload(1'b1, 10'd3, 16'hFFFF);
    exp_q.push_back('{rdata: last_rd, err: 1'b0});
    issue(17'h10003, 1'b1, 2'b11, 16'h0010);
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL ctrl_busy: got %b want 1", busy); end
    wait_ack(200, seen, ticks, low_tick, cu, cl, crw, cva, rw_low);
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL ctrl_ack: got none want ack"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++;
      if (ticks < 3 || ticks > 4) begin bad++; $display("[TB] FAIL ctrl_latency: got %0d ticks want 3..4", ticks); end
      total++;
      if ({err, rdata} !== {e.err, e.rdata}) begin
        bad++; $display("[TB] FAIL ctrl_result: got err=%b rdata=%h want err=%b rdata=%h", err, rdata, e.err, e.rdata);
      end
      total++;
      if ({cu, cl, crw, cva} !== {3'b000, 17'h10003}) begin
        bad++; $display("[TB] FAIL ctrl_strobes: got U=%b L=%b RW=%b VA=%h want 0 0 0 10003", cu, cl, crw, cva);
      end
    end
    wait_idle(ok);
    total++;
    if (!ok || ctrl[3] !== 16'h0010) begin
      bad++; $display("[TB] FAIL ctrl_reg: got idle=%b ctrl3=%h want 1 0010", ok, ctrl[3]);
    end
  endtask

  task automatic test_ram_read();
    bit seen, rw_low, ok; int ticks, low_tick; logic cu, cl, crw; logic [16:0] cva; exp_t e;
    preload(1'b0, 10'h200, 16'hBEEF);
    ram_lat = $urandom_range(20, 30);
    exp_q.push_back('{rdata: 16'hBEEF, err: 1'b0});
    issue(17'h00200, 1'b0, 2'b11, 16'h0000);
    wait_ack(400, seen, ticks, low_tick, cu, cl, crw, cva, rw_low);
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL ram_ack: got none want ack"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      last_rd = e.rdata;
      total++;
      if (ticks > 34) begin bad++; $display("[TB] FAIL ram_latency: got %0d ticks want <=34", ticks); end
      total++;
      if ({err, rdata} !== {e.err, e.rdata}) begin
        bad++; $display("[TB] FAIL ram_result: got err=%b rdata=%h want err=%b rdata=%h", err, rdata, e.err, e.rdata);
      end
      total++;
      if (rw_low || cva !== 17'h00200) begin
        bad++; $display("[TB] FAIL ram_rw: got rw_low=%b VA=%h want 0 00200", rw_low, cva);
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_byte_write();
    bit seen, rw_low, ok; int ticks, low_tick; logic cu, cl, crw; logic [16:0] cva; exp_t e;
    preload(1'b0, 10'h123, 16'h1234);
    ram_lat = 5;
    exp_q.push_back('{rdata: last_rd, err: 1'b0});
    issue(17'h00123, 1'b1, 2'b10, 16'hA55A);
    wait_ack(200, seen, ticks, low_tick, cu, cl, crw, cva, rw_low);
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL byte_ack: got none want ack"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++;
      if ({cu, cl, crw} !== 3'b010) begin
        bad++; $display("[TB] FAIL byte_strobes: got U=%b L=%b RW=%b want 0 1 0", cu, cl, crw);
      end
      total++;
      if ({err, rdata} !== {e.err, e.rdata}) begin
        bad++; $display("[TB] FAIL byte_result: got err=%b rdata=%h want err=%b rdata=%h", err, rdata, e.err, e.rdata);
      end
    end
    wait_idle(ok);
    total++;
    if (ram[10'h123] !== 16'hA534) begin
      bad++; $display("[TB] FAIL byte_ram: got %h want a534", ram[10'h123]);
    end
  endtask

  task automatic test_no_enable();
    exp_t e;
    exp_q.push_back('{rdata: last_rd, err: 1'b0});
    issue(17'h10004, 1'b1, 2'b00, 16'h7777);
    e = exp_q.pop_front();
    total++;
    if ({ack, busy, err, rdata, bus.SCCSn} !== {2'b11, e.err, e.rdata, 1'b1}) begin
      bad++; $display("[TB] FAIL noen_ack: got ack=%b busy=%b err=%b rdata=%h cs=%b want 1 1 %b %h 1",
                      ack, busy, err, rdata, bus.SCCSn, e.err, e.rdata);
    end
    @(negedge clk);
    total++;
    if ({ack, busy} !== 2'b00) begin
      bad++; $display("[TB] FAIL noen_done: got ack=%b busy=%b want 0 0", ack, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit seen, rw_low, ok; int ticks, low_tick, ack_tick, fall_tick, extra; logic cu, cl, crw; logic [16:0] cva; exp_t e;
    preload(1'b1, 10'd5, 16'h5A5A);
    preload(1'b1, 10'd6, 16'h0000);
    exp_q.push_back('{rdata: 16'h5A5A, err: 1'b0});
    issue(17'h10005, 1'b0, 2'b11, 16'h0000);
    issue(17'h10006, 1'b1, 2'b11, 16'hDEAD);
    wait_ack(200, seen, ticks, low_tick, cu, cl, crw, cva, rw_low);
    ack_tick = tick_cnt;
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL b2b_ack: got none want ack"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      last_rd = e.rdata;
      total++;
      if ({err, rdata} !== {e.err, e.rdata}) begin
        bad++; $display("[TB] FAIL b2b_result: got err=%b rdata=%h want err=%b rdata=%h", err, rdata, e.err, e.rdata);
      end
    end
    extra = 0; fall_tick = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack === 1'b1) extra++;
      if (busy === 1'b0) begin fall_tick = tick_cnt; break; end
    end
    total++;
    if (fall_tick - ack_tick != 2) begin
      bad++; $display("[TB] FAIL b2b_recovery: got %0d ticks want 2", fall_tick - ack_tick);
    end
    exp_q.push_back('{rdata: 16'h5A5A, err: 1'b0});
    issue(17'h10005, 1'b0, 2'b11, 16'h0000);
    wait_ack(200, seen, ticks, low_tick, cu, cl, crw, cva, rw_low);
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL b2b_second: got none want ack"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      total++;
      if (rdata !== e.rdata || low_tick - ack_tick < 3) begin
        bad++; $display("[TB] FAIL b2b_gap: got rdata=%h gap=%0d want %h >=3", rdata, low_tick - ack_tick, e.rdata);
      end
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack === 1'b1) extra++;
    end
    total++;
    if (extra != 0 || ctrl[6] !== 16'h0000) begin
      bad++; $display("[TB] FAIL b2b_ignored: got extra_acks=%0d ctrl6=%h want 0 0000", extra, ctrl[6]);
    end
  endtask

`ifdef SCN_BUS_TIMEOUT_EN
  task automatic test_timeout();
    bit seen, rw_low, ok; int ticks, low_tick; logic cu, cl, crw; logic [16:0] cva; exp_t e;
    hold_high = 1'b1;
    exp_q.push_back('{rdata: 16'hFFFF, err: 1'b1});
    issue(17'h00010, 1'b0, 2'b11, 16'h0000);
    wait_ack(600, seen, ticks, low_tick, cu, cl, crw, cva, rw_low);
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL timeout_ack: got none want ack"); exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      last_rd = e.rdata;
      total++;
      if ({err, rdata} !== {e.err, e.rdata} || ticks != 66) begin
        bad++; $display("[TB] FAIL timeout_result: got err=%b rdata=%h ticks=%0d want %b %h 66", err, rdata, ticks, e.err, e.rdata);
      end
      total++;
      if ({bus.SCCSn, bus.UDSn, bus.LDSn, bus.RW} !== 4'b1111) begin
        bad++; $display("[TB] FAIL timeout_release: got %b want 1111", {bus.SCCSn, bus.UDSn, bus.LDSn, bus.RW});
      end
    end
    hold_high = 1'b0;
    wait_idle(ok);
  endtask
`endif

  task automatic test_reset_mid_cycle();
    int acks;
    hold_high = 1'b1;
    issue(17'h10002, 1'b0, 2'b11, 16'h0000);
    for (int i = 0; i < 100; i++) begin
      if (bus.SCCSn === 1'b0) break;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    total++;
    if ({busy, bus.SCCSn} !== 2'b10) begin
      bad++; $display("[TB] FAIL midrst_inwait: got busy=%b cs=%b want 1 0", busy, bus.SCCSn);
    end
    resetn = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.SCCSn, bus.UDSn, bus.LDSn, bus.RW, busy, ack, err} !== 7'b1111000) begin
      bad++; $display("[TB] FAIL midrst_state: got %b want 1111000",
                      {bus.SCCSn, bus.UDSn, bus.LDSn, bus.RW, busy, ack, err});
    end
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    resetn = 1'b1;
    hold_high = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    total++;
    if (acks != 0 || rdata !== 16'h0000) begin
      bad++; $display("[TB] FAIL midrst_noack: got acks=%0d rdata=%h want 0 0000", acks, rdata);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_ctrl_write();
    test_ram_read();
    test_byte_write();
    test_no_enable();
    test_back_to_back();
`ifdef SCN_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
